// File: rtl/input_mapper_pkg.sv
// rtl/input_mapper_pkg.sv - shared constants, bit positions and sequencer state type
// Scan codes, joystick/output bit indices and the coin/start sequencer states.
package input_map_pkg;

   // Direction codes match on the low byte only, so E0-prefixed keypad arrows alias them.
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [8:0] SC_FIRE_A = 9'h029;
   localparam logic [8:0] SC_FIRE_B = 9'h014;
   localparam logic [8:0] SC_START1 = 9'h005;
   localparam logic [8:0] SC_START2 = 9'h006;

   localparam int JOY_RIGHT  = 0;
   localparam int JOY_LEFT   = 1;
   localparam int JOY_DOWN   = 2;
   localparam int JOY_UP     = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_START1 = 5;
   localparam int JOY_START2 = 6;
   localparam int JOY_COIN   = 7;

   localparam int IN0_UP     = 0;
   localparam int IN0_LEFT   = 1;
   localparam int IN0_RIGHT  = 2;
   localparam int IN0_DOWN   = 3;
   localparam int IN0_FIRE   = 4;
   localparam int IN0_COIN   = 5;
   localparam int IN1_START1 = 5;
   localparam int IN1_START2 = 6;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_COIN,
      SEQ_GAP,
      SEQ_START,
      SEQ_RELEASE
   } seq_state_t;

endpackage

// File: rtl/input_mapper_if.sv
// rtl/input_mapper_if.sv - player input bundle between input sources and the core input bytes
// Source side drives keyboard/joystick/orientation; mapper side drives in0/in1/busy.
interface input_mapper_if;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;
   logic        rotate;
   logic [7:0]  in0;
   logic [7:0]  in1;
   logic        busy;

   modport master (
      output ps2_key, joystick_0, joystick_1, rotate,
      input  in0, in1, busy
   );

   modport slave (
      input  ps2_key, joystick_0, joystick_1, rotate,
      output in0, in1, busy
   );
endinterface

// File: rtl/input_mapper_coin_start_seq.sv
// rtl/input_mapper_coin_start_seq.sv - timed coin then start pulse sequencer
// One start press yields coin, idle gap, then the chosen start line; re-arms only after release.
module coin_start_seq
   import input_map_pkg::*;
#(
   parameter int CW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s1,
   input  logic          s2,
   input  logic [CW-1:0] coin_len,
   input  logic [CW-1:0] gap_len,
   input  logic [CW-1:0] start_len,
   output logic          seq_coin,
   output logic [1:0]    seq_start,
   output logic          busy
);

   seq_state_t    state_q;
   logic [CW-1:0] cnt_q;
   logic          sel_q;
   logic          coin_q;
   logic [1:0]    start_q;
   logic          busy_q;

   // Outputs are loaded on the transition into each phase so they line up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         coin_q  <= 1'b0;
         start_q <= 2'b00;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (s1 || s2) begin
                  sel_q   <= ~s1;
                  cnt_q   <= coin_len - CW'(1);
                  state_q <= SEQ_COIN;
                  coin_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SEQ_COIN: begin
               if (cnt_q == '0) begin
                  cnt_q   <= gap_len - CW'(1);
                  state_q <= SEQ_GAP;
                  coin_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            SEQ_GAP: begin
               if (cnt_q == '0) begin
                  cnt_q   <= start_len - CW'(1);
                  state_q <= SEQ_START;
                  start_q <= sel_q ? 2'b10 : 2'b01;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            SEQ_START: begin
               if (cnt_q == '0) begin
                  state_q <= SEQ_RELEASE;
                  start_q <= 2'b00;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            SEQ_RELEASE: begin
               if (!s1 && !s2) begin
                  state_q <= SEQ_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= SEQ_IDLE;
         endcase
      end
   end

   assign seq_coin  = coin_q;
   assign seq_start = start_q;
   assign busy      = busy_q;

endmodule

// File: rtl/input_mapper.sv
// rtl/input_mapper.sv - merges PS/2 keys and joysticks into the core's active-low input bytes
// Holds the key latch, joystick merge, orientation remap and registered in0/in1.
module input_mapper
   import input_map_pkg::*;
#(
   parameter int COIN_LEN  = 2_457_600,
   parameter int GAP_LEN   = 4_915_200,
   parameter int START_LEN = 2_457_600,
   parameter int CW        = 24
) (
   input  logic           CLK,
   input  logic           RESET,
   input_mapper_if.slave  bus
);

   logic ps2_tog_q, ps2_tog_d;
   logic key_up_q, key_up_d, key_down_q, key_down_d;
   logic key_left_q, key_left_d, key_right_q, key_right_d;
   logic key_fire_q, key_fire_d, key_s1_q, key_s1_d, key_s2_q, key_s2_d;
   logic [7:0] in0_q, in0_d, in1_q, in1_d;

   logic [15:0] joy;
   logic        raw_u, raw_d, raw_l, raw_r, raw_f, raw_s1, raw_s2;
   logic        up, down, left, right, coin;
   logic        seq_coin, seq_busy;
   logic [1:0]  seq_start;
   logic        ps2_event, ps2_pressed;
   logic [8:0]  ps2_code;
   logic        unused_joy;

   assign ps2_event   = bus.ps2_key[10] != ps2_tog_q;
   assign ps2_pressed = bus.ps2_key[9];
   assign ps2_code    = bus.ps2_key[8:0];

   always_comb begin
      ps2_tog_d   = bus.ps2_key[10];
      key_up_d    = key_up_q;
      key_down_d  = key_down_q;
      key_left_d  = key_left_q;
      key_right_d = key_right_q;
      key_fire_d  = key_fire_q;
      key_s1_d    = key_s1_q;
      key_s2_d    = key_s2_q;
      if (ps2_event) begin
         if (ps2_code[7:0] == SC_UP)         key_up_d    = ps2_pressed;
         else if (ps2_code[7:0] == SC_DOWN)  key_down_d  = ps2_pressed;
         else if (ps2_code[7:0] == SC_LEFT)  key_left_d  = ps2_pressed;
         else if (ps2_code[7:0] == SC_RIGHT) key_right_d = ps2_pressed;
         else if (ps2_code == SC_FIRE_A || ps2_code == SC_FIRE_B) key_fire_d = ps2_pressed;
         else if (ps2_code == SC_START1)     key_s1_d    = ps2_pressed;
         else if (ps2_code == SC_START2)     key_s2_d    = ps2_pressed;
      end
   end

   assign joy        = bus.joystick_0 | bus.joystick_1;
   assign unused_joy = ^joy[15:8];

   assign raw_u  = key_up_q    | joy[JOY_UP];
   assign raw_d  = key_down_q  | joy[JOY_DOWN];
   assign raw_l  = key_left_q  | joy[JOY_LEFT];
   assign raw_r  = key_right_q | joy[JOY_RIGHT];
   assign raw_f  = key_fire_q  | joy[JOY_FIRE];
   assign raw_s1 = key_s1_q    | joy[JOY_START1];
   assign raw_s2 = key_s2_q    | joy[JOY_START2];

   // Horizontal cabinet: the stick is turned a quarter, so each axis maps to its neighbour.
   assign up    = bus.rotate ? raw_l : raw_u;
   assign down  = bus.rotate ? raw_r : raw_d;
   assign left  = bus.rotate ? raw_d : raw_l;
   assign right = bus.rotate ? raw_u : raw_r;
   assign coin  = seq_coin | joy[JOY_COIN];

   coin_start_seq #(.CW(CW)) u_seq (
      .clk       (CLK),
      .rst       (RESET),
      .s1        (raw_s1),
      .s2        (raw_s2),
      .coin_len  (CW'(COIN_LEN)),
      .gap_len   (CW'(GAP_LEN)),
      .start_len (CW'(START_LEN)),
      .seq_coin  (seq_coin),
      .seq_start (seq_start),
      .busy      (seq_busy)
   );

   always_comb begin
      in0_d             = 8'hFF;
      in0_d[IN0_UP]     = ~up;
      in0_d[IN0_LEFT]   = ~left;
      in0_d[IN0_RIGHT]  = ~right;
      in0_d[IN0_DOWN]   = ~down;
      in0_d[IN0_FIRE]   = ~raw_f;
      in0_d[IN0_COIN]   = ~coin;
      in1_d             = 8'hFF;
      in1_d[IN1_START1] = ~seq_start[0];
      in1_d[IN1_START2] = ~seq_start[1];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ps2_tog_q   <= bus.ps2_key[10];
         key_up_q    <= 1'b0;
         key_down_q  <= 1'b0;
         key_left_q  <= 1'b0;
         key_right_q <= 1'b0;
         key_fire_q  <= 1'b0;
         key_s1_q    <= 1'b0;
         key_s2_q    <= 1'b0;
         in0_q       <= 8'hFF;
         in1_q       <= 8'hFF;
      end else begin
         ps2_tog_q   <= ps2_tog_d;
         key_up_q    <= key_up_d;
         key_down_q  <= key_down_d;
         key_left_q  <= key_left_d;
         key_right_q <= key_right_d;
         key_fire_q  <= key_fire_d;
         key_s1_q    <= key_s1_d;
         key_s2_q    <= key_s2_d;
         in0_q       <= in0_d;
         in1_q       <= in1_d;
      end
   end

   assign bus.in0  = in0_q;
   assign bus.in1  = in1_q;
   assign bus.busy = seq_busy;

endmodule

// File: tb/tb_input_mapper.sv
// tb/tb_input_mapper.sv - directed self-checking bench for input_mapper
// Short phase lengths so whole coin/gap/start sequences fit in a few dozen cycles.
module tb_input_mapper;

   localparam int C = 4;
   localparam int G = 3;
   localparam int S = 5;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n_coin, n_s1, n_s2;

   input_mapper_if bus ();

   input_mapper #(.COIN_LEN(C), .GAP_LEN(G), .START_LEN(S), .CW(8)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.ps2_key    = 11'h400;
      bus.joystick_0 = 16'h0000;
      bus.joystick_1 = 16'h0000;
      bus.rotate     = 1'b0;
      tick(2);
      chk("reset_in0", bus.in0, 8'hFF);
      chk("reset_in1", bus.in1, 8'hFF);
      chk("reset_busy", {7'b0, bus.busy}, 8'h00);
      rst = 1'b0;
      tick(2);
      chk("post_reset_in0", bus.in0, 8'hFF);

      bus.joystick_1 = 16'h0008;
      tick(1);
      chk("joy_up", bus.in0, 8'hFE);
      bus.joystick_1 = 16'h0000;
      bus.rotate     = 1'b1;
      bus.joystick_0 = 16'h0002;
      tick(1);
      chk("rot_left_to_up", bus.in0, 8'hFE);
      bus.joystick_0 = 16'h0008;
      tick(1);
      chk("rot_up_to_right", bus.in0, 8'hFB);
      bus.joystick_0 = 16'h0004;
      tick(1);
      chk("rot_down_to_left", bus.in0, 8'hFD);
      bus.joystick_0 = 16'h0000;
      bus.rotate     = 1'b0;
      tick(1);
      chk("joy_idle", bus.in0, 8'hFF);

      bus.ps2_key = {1'b0, 1'b1, 9'h175};
      tick(1);
      chk("ps2_up_latency", bus.in0, 8'hFF);
      tick(1);
      chk("ps2_up_press", bus.in0, 8'hFE);
      bus.ps2_key = {1'b1, 1'b0, 9'h175};
      tick(2);
      chk("ps2_up_release", bus.in0, 8'hFF);
      bus.ps2_key = {1'b0, 1'b1, 9'h0F0};
      tick(2);
      chk("ps2_ignored", bus.in0, 8'hFF);
      bus.ps2_key = {1'b1, 1'b1, 9'h029};
      tick(2);
      chk("ps2_fire", bus.in0, 8'hEF);
      bus.ps2_key = {1'b0, 1'b0, 9'h029};
      tick(2);
      chk("ps2_fire_rel", bus.in0, 8'hFF);

      // Single-cycle start1 pulse: edge k counted from the edge that sees the trigger.
      bus.joystick_0 = 16'h0020;
      tick(1);
      bus.joystick_0 = 16'h0000;
      chk("seq_busy_t1", {7'b0, bus.busy}, 8'h01);
      chk("seq_in0_t1", bus.in0, 8'hFF);
      for (int k = 2; k <= 2 + C + G + S; k++) begin
         tick(1);
         chk($sformatf("seq_in0_k%0d", k), bus.in0,
             (k >= 2 && k <= 1 + C) ? 8'hDF : 8'hFF);
         chk($sformatf("seq_in1_k%0d", k), bus.in1,
             (k >= 2 + C + G && k <= 1 + C + G + S) ? 8'hDF : 8'hFF);
         chk($sformatf("seq_busy_k%0d", k), {7'b0, bus.busy},
             (k <= 1 + C + G + S) ? 8'h01 : 8'h00);
      end

      // Held start1: one sequence, then parked in RELEASE until the button is let go.
      n_coin = 0;
      n_s1   = 0;
      bus.joystick_0 = 16'h0020;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (bus.in0[5] == 1'b0) n_coin++;
         if (bus.in1[5] == 1'b0) n_s1++;
      end
      chk("hold_coin_cycles", 8'(n_coin), 8'(C));
      chk("hold_s1_cycles", 8'(n_s1), 8'(S));
      chk("hold_busy", {7'b0, bus.busy}, 8'h01);
      bus.joystick_0 = 16'h0000;
      tick(1);
      chk("hold_released", {7'b0, bus.busy}, 8'h00);
      tick(2);
      chk("hold_no_retrigger", {7'b0, bus.busy}, 8'h00);

      // S1 and S2 together, plus a late S2 press during the gap.
      n_s1 = 0;
      n_s2 = 0;
      bus.joystick_0 = 16'h0060;
      for (int k = 1; k <= 2 + C + G + S; k++) begin
         tick(1);
         bus.joystick_0 = 16'h0000;
         bus.joystick_1 = (k == C + 2) ? 16'h0040 : 16'h0000;
         if (bus.in1[5] == 1'b0) n_s1++;
         if (bus.in1[6] == 1'b0) n_s2++;
      end
      chk("both_s1_cycles", 8'(n_s1), 8'(S));
      chk("both_s2_cycles", 8'(n_s2), 8'h00);
      chk("both_idle", {7'b0, bus.busy}, 8'h00);

      // Reset while the start line is active.
      bus.joystick_0 = 16'h0020;
      tick(1);
      bus.joystick_0 = 16'h0000;
      tick(C + G + 1);
      chk("rst_pre_in1", bus.in1, 8'hDF);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_in1", bus.in1, 8'hFF);
      chk("rst_mid_busy", {7'b0, bus.busy}, 8'h00);
      rst = 1'b0;
      tick(3);
      chk("rst_after_in1", bus.in1, 8'hFF);
      chk("rst_after_busy", {7'b0, bus.busy}, 8'h00);

      bus.joystick_0 = 16'h0080;
      tick(1);
      chk("coin_direct", bus.in0, 8'hDF);
      bus.joystick_0 = 16'h0000;
      tick(1);
      chk("coin_direct_off", bus.in0, 8'hFF);

      // Direct coin during the gap is still a one-cycle bypass.
      bus.joystick_0 = 16'h0020;
      tick(1);
      bus.joystick_0 = 16'h0000;
      tick(C + 2);
      chk("gap_quiet", bus.in0, 8'hFF);
      bus.joystick_0 = 16'h0080;
      tick(1);
      chk("gap_coin_direct", bus.in0, 8'hDF);
      bus.joystick_0 = 16'h0000;
      tick(1);
      chk("gap_coin_off", bus.in0, 8'hFF);
      tick(S + 3);
      chk("final_busy", {7'b0, bus.busy}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
